keccak_round_sched: RTL and testbench

//   Top-level sequencer for the Keccak-f permutation engine. It runs NUM_ROUNDS rounds.

---
 rtl/keccak_round_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_keccak_round_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_sched.sv
// keccak_round_sched
//   Sequencer for the Keccak-f permutation engine. For each of NUM_ROUNDS rounds it
//   issues the N_STEPS step units (theta, rho, pi, chi, iota) in order. Each unit gets a
//   one-cycle start pulse, and the sequencer waits for that unit's own done pulse.
//   It also drives the round index used by the round-constant ROM and pulses ready
//   when the whole permutation has finished.
//   Optional feature: define STEP_TIMEOUT_EN to add a per-step watchdog and a sticky
//   ERR state. Without it, err is tied low and WAIT waits indefinitely.
module keccak_round_sched #(
    parameter int N_STEPS    = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int RW         = 5,
    parameter int SW         = 3,
    parameter int TIMEOUT    = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_STEPS-1:0] step_done,
    output logic [N_STEPS-1:0] step_start,
    output logic [SW-1:0]      step_idx,
    output logic [RW-1:0]      round_idx,
    output logic               busy,
    output logic               ready,
    output logic               err
);

    // Reject parameter sets where the indices cannot hold their full range.
    if ((2**RW < NUM_ROUNDS) || (2**SW < N_STEPS) || (N_STEPS < 1) || (NUM_ROUNDS < 1) ||
        (TIMEOUT < 1)) begin : g_bad_params
        $error("keccak_round_sched: inconsistent parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [SW-1:0] LAST_STEP  = SW'(N_STEPS - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    state_t             state_q, state_d;
    logic [SW-1:0]      step_idx_q, step_idx_d;
    logic [RW-1:0]      round_idx_q, round_idx_d;
    logic [N_STEPS-1:0] sel_mask;
    logic               active_done;
    logic               last_step;
    logic               last_round;

`ifdef STEP_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           wd_expire;
`endif

    // Decode the active step index into a one-hot select used for both start and done.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_STEPS; i++) begin
            sel_mask[i] = (step_idx_q == SW'(i));
        end
    end

    // Only the active unit's done pulse can advance the sequence.
    assign active_done = |(step_done & sel_mask);
    assign last_step   = (step_idx_q == LAST_STEP);
    assign last_round  = (round_idx_q == LAST_ROUND);

`ifdef STEP_TIMEOUT_EN
    // The counter reaching TIMEOUT on this WAIT cycle means the unit has stalled.
    assign wd_expire = (state_q == S_WAIT) && (wd_q == WD_LAST);

    // Watchdog: cleared on each issue, counts WAIT cycles while the step is outstanding.
    always_comb begin
        wd_d = wd_q;
        case (state_q)
            S_ISSUE: wd_d = '0;
            S_WAIT:  wd_d = wd_q + 1'b1;
            default: wd_d = '0;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done pulse on the timeout cycle takes priority over the error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (active_done) begin
                    if (last_step && last_round) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
`ifdef STEP_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef STEP_TIMEOUT_EN
            S_ERR: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Step/round index update: advance on the active done, clear on the way back to IDLE
    // or on a restart from ERR, otherwise hold (indices never wrap).
    always_comb begin
        step_idx_d  = step_idx_q;
        round_idx_d = round_idx_q;
        case (state_q)
            S_WAIT: begin
                if (active_done) begin
                    if (!last_step) begin
                        step_idx_d = step_idx_q + 1'b1;
                    end else if (!last_round) begin
                        step_idx_d  = '0;
                        round_idx_d = round_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                step_idx_d  = '0;
                round_idx_d = '0;
            end
`ifdef STEP_TIMEOUT_EN
            S_ERR: begin
                if (start) begin
                    step_idx_d  = '0;
                    round_idx_d = '0;
                end
            end
`endif
            default: begin
                step_idx_d  = step_idx_q;
                round_idx_d = round_idx_q;
            end
        endcase
    end

    // Index registers (and watchdog when enabled).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_idx_q  <= '0;
            round_idx_q <= '0;
`ifdef STEP_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            step_idx_q  <= step_idx_d;
            round_idx_q <= round_idx_d;
`ifdef STEP_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Outputs decoded from the state; step_start is one-hot only in ISSUE.
    always_comb begin
        step_start = '0;
        busy       = 1'b0;
        ready      = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_ISSUE: begin
                step_start = sel_mask;
                busy       = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                ready = 1'b1;
            end
`ifdef STEP_TIMEOUT_EN
            S_ERR: begin
                err = 1'b1;
            end
`endif
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign step_idx  = step_idx_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_keccak_round_sched.sv
// tb_keccak_round_sched
//   Directed sequence with randomized step-unit delays and spurious done pulses.
//   The reference model: the k-th start pulse of a permutation must target step k%N in
//   round k/N, and ready must land NUM_ROUNDS * sum(D_i+1) cycles after the ISSUE cycle
//   that follows the start sample. Build with STEP_TIMEOUT_EN to add the watchdog cases.
module tb_keccak_round_sched;

    localparam int NS    = 5;
    localparam int NR    = 24;
    localparam int RWB   = 5;
    localparam int SWB   = 3;
    localparam int TOTAL = NS * NR;
`ifdef STEP_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 2048;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [NS-1:0]  step_done = '0;
    logic [NS-1:0]  step_start;
    logic [SWB-1:0] step_idx;
    logic [RWB-1:0] round_idx;
    logic           busy;
    logic           ready;
    logic           err;

    keccak_round_sched #(
        .N_STEPS    (NS),
        .NUM_ROUNDS (NR),
        .RW         (RWB),
        .SW         (SWB),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_done  (step_done),
        .step_start (step_start),
        .step_idx   (step_idx),
        .round_idx  (round_idx),
        .busy       (busy),
        .ready      (ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            dly [NS];
    int            cnt [NS];
    bit            hold [NS];
    logic [NS-1:0] inj = '0;
    bit            spur_en = 1'b0;
    int            pulse_k = 0;
    int            cur_step = 0;
    int            ready_cnt = 0;
    int            ready_cyc = -1;
    int            start_cyc = 0;
    int            busy_cnt = 0;
    int            err_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected cycles from the ISSUE cycle after the start sample to the ready cycle.
    function automatic int perm_cycles();
        int s = 0;
        for (int i = 0; i < NS; i++) s += dly[i] + 1;
        return NR * s;
    endfunction

    task automatic set_dly(input int d);
        for (int i = 0; i < NS; i++) dly[i] = d;
    endtask

    // One clock: sample outputs 1 time unit after the edge, then model the step units.
    task automatic tick();
        logic [NS-1:0] nd;
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (err !== 1'b0) err_hi++;
        if (step_start !== '0) begin
            chk("pulse_in_range", pulse_k < TOTAL, 1);
            chk("step_start", step_start, NS'(1) << (pulse_k % NS));
            chk("step_idx", step_idx, pulse_k % NS);
            chk("round_idx", round_idx, pulse_k / NS);
            cur_step = pulse_k % NS;
            pulse_k++;
        end
        if (ready === 1'b1) begin
            chk("ready_all_steps", pulse_k, TOTAL);
            chk("ready_busy_low", busy, 0);
            chk("ready_round_hold", round_idx, NR - 1);
            chk("ready_step_hold", step_idx, NS - 1);
            ready_cnt++;
            ready_cyc = cyc;
        end
        nd  = inj;
        inj = '0;
        for (int i = 0; i < NS; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0 && !hold[i]) nd[i] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (step_start[i] === 1'b1) cnt[i] = dly[i];
        end
        if (spur_en && busy === 1'b1) nd |= NS'($urandom) & ~(NS'(1) << cur_step);
        step_done = nd;
    endtask

    task automatic begin_perm();
        pulse_k   = 0;
        cur_step  = 0;
        busy_cnt  = 0;
        ready_cnt = 0;
        ready_cyc = -1;
        err_hi    = 0;
        start     = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start     = 1'b0;
    endtask

    task automatic finish_perm(input string tag, input int exp_lat, input int wait_start_at,
                               input bit start_in_done);
        int n;
        n = 0;
        while (ready_cnt == 0 && n < 20000) begin
            start = (n == wait_start_at);
            tick();
            n++;
        end
        start = 1'b0;
        chk({tag, " ready_seen"}, ready_cnt, 1);
        if (exp_lat >= 0) begin
            chk({tag, " ready_latency"}, ready_cyc - start_cyc, exp_lat);
            chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
        end
        chk({tag, " no_err"}, err_hi, 0);
        start = start_in_done;
        tick();
        start = 1'b0;
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " idle_step_idx"}, step_idx, 0);
        chk({tag, " idle_round_idx"}, round_idx, 0);
        chk({tag, " idle_step_start"}, step_start, 0);
        repeat (3) tick();
        chk({tag, " single_ready"}, ready_cnt, 1);
        chk({tag, " stays_idle"}, busy, 0);
        chk({tag, " pulse_total"}, pulse_k, TOTAL);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " step_start"}, step_start, 0);
        chk({tag, " step_idx"}, step_idx, 0);
        chk({tag, " round_idx"}, round_idx, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " ready"}, ready, 0);
        chk({tag, " err"}, err, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NS; i++) begin
            dly[i]  = 1;
            cnt[i]  = 0;
            hold[i] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Every unit answers one cycle after its start
        set_dly(1);
        begin_perm();
        finish_perm("d1", perm_cycles(), -1, 1'b0);

        // Three-cycle units
        set_dly(3);
        begin_perm();
        finish_perm("d3", perm_cycles(), -1, 1'b0);

        // Random per-unit delays with random done pulses from idle units
        spur_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NS; i++) dly[i] = $urandom_range(1, 4);
            begin_perm();
            finish_perm("rand", perm_cycles(), -1, 1'b0);
        end
        spur_en = 1'b0;

        // Spurious step_done[3] while step 1 is outstanding must not advance
        set_dly(1);
        hold[1] = 1'b1;
        begin_perm();
        n = 0;
        while (pulse_k < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("spur step1_issued", pulse_k, 2);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) inj = 5'b01000;
            tick();
        end
        chk("spur step_idx", step_idx, 1);
        chk("spur round_idx", round_idx, 0);
        chk("spur busy", busy, 1);
        chk("spur no_advance", pulse_k, 2);
        chk("spur err", err, 0);
        hold[1] = 1'b0;
        inj = 5'b00010;
        finish_perm("spur", -1, -1, 1'b0);

        // start during WAIT and during DONE is ignored
        set_dly(2);
        begin_perm();
        finish_perm("start_ign", perm_cycles(), 101, 1'b1);

        // Asynchronous reset in round 7, step 2
        set_dly(1);
        begin_perm();
        n = 0;
        while (pulse_k < 7 * NS + 3 && n < 500) begin
            tick();
            n++;
        end
        chk("abort reached_r7s2", pulse_k, 7 * NS + 3);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        step_done = '0;
        tick();
        tick();
        chk("abort no_ready", ready_cnt, 0);
        rst = 1'b1;
        tick();
        check_all_zero("abort_release");
        begin_perm();
        finish_perm("after_abort", perm_cycles(), -1, 1'b0);

`ifdef STEP_TIMEOUT_EN
        // Withheld done on step 4 trips the watchdog after TO WAIT cycles
        set_dly(1);
        hold[4] = 1'b1;
        begin_perm();
        n = 0;
        while (pulse_k < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("to step4_issued", pulse_k, 5);
        repeat (TO) tick();
        chk("to err_before", err, 0);
        chk("to busy_before", busy, 1);
        tick();
        chk("to err", err, 1);
        chk("to busy", busy, 0);
        chk("to step_start", step_start, 0);
        chk("to step_idx_hold", step_idx, 4);
        chk("to round_idx_hold", round_idx, 0);
        repeat (5) tick();
        chk("to err_sticky", err, 1);
        chk("to no_ready", ready_cnt, 0);
        hold[4] = 1'b0;
        begin_perm();
        chk("to err_cleared", err, 0);
        finish_perm("to_rerun", perm_cycles(), -1, 1'b0);

        // Done on the same cycle the watchdog expires: done wins
        set_dly(1);
        dly[0] = TO;
        begin_perm();
        finish_perm("done_wins", perm_cycles(), -1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
